line_draw_engine: RTL and testbench



---
 rtl/gfx_pkg.sv | 55 +++++
 rtl/bresenham_step.sv | 41 ++++
 rtl/line_draw_engine.sv | 152 +++++++++++++++
 tb/tb_line_draw_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared constants, state type and helpers for the line rasteriser.
// When DRAW_CLIP_EN is defined, endpoints become signed and off-screen pixels are skipped.
package gfx_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 200;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int ERR_W    = 11;

`ifdef DRAW_CLIP_EN
    localparam int CX_W = X_W + 1;
    localparam int CY_W = Y_W + 1;
`else
    localparam int CX_W = X_W;
    localparam int CY_W = Y_W;
`endif

    localparam logic [ERR_W-1:0] SCREEN_W_C = ERR_W'(SCREEN_W);
    localparam logic [ERR_W-1:0] SCREEN_H_C = ERR_W'(SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_STEP
    } draw_state_t;

    // Coordinates are carried internally as ERR_W-bit two's complement.
    typedef struct packed {
        logic [ERR_W-1:0] x;
        logic [ERR_W-1:0] y;
    } pixel_xy_t;

    function automatic logic on_screen(input pixel_xy_t p);
        return !p.x[ERR_W-1] && !p.y[ERR_W-1] && (p.x < SCREEN_W_C) && (p.y < SCREEN_H_C);
    endfunction

    function automatic logic [ERR_W-1:0] ext_x(input logic [CX_W-1:0] v);
`ifdef DRAW_CLIP_EN
        return {{(ERR_W-CX_W){v[CX_W-1]}}, v};
`else
        return {{(ERR_W-CX_W){1'b0}}, v};
`endif
    endfunction

    function automatic logic [ERR_W-1:0] ext_y(input logic [CY_W-1:0] v);
`ifdef DRAW_CLIP_EN
        return {{(ERR_W-CY_W){v[CY_W-1]}}, v};
`else
        return {{(ERR_W-CY_W){1'b0}}, v};
`endif
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: both axis decisions use the incoming error term.
module bresenham_step
    import gfx_pkg::*;
(
    input  logic [ERR_W-1:0] acc,
    input  logic [ERR_W-1:0] dx,
    input  logic [ERR_W-1:0] dy,
    input  logic             sx_neg,
    input  logic             sy_neg,
    input  pixel_xy_t        cur,
    output logic [ERR_W-1:0] acc_next,
    output pixel_xy_t        nxt
);

    localparam logic [ERR_W-1:0] ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic signed [ERR_W:0] e2;
    logic signed [ERR_W:0] dx_w;
    logic signed [ERR_W:0] dy_w;
    logic                  step_x;
    logic                  step_y;
    logic [ERR_W-1:0]      acc_x;

    always_comb begin
        e2       = signed'({acc, 1'b0});
        dx_w     = signed'({dx[ERR_W-1], dx});
        dy_w     = signed'({dy[ERR_W-1], dy});
        step_x   = (e2 >= dy_w);
        step_y   = (e2 <= dx_w);
        acc_x    = step_x ? acc + dy : acc;
        acc_next = step_y ? acc_x + dx : acc_x;
        nxt      = cur;
        if (step_x) begin
            nxt.x = sx_neg ? cur.x - ONE : cur.x + ONE;
        end
        if (step_y) begin
            nxt.y = sy_neg ? cur.y - ONE : cur.y + ONE;
        end
    end

endmodule

// File: rtl/line_draw_engine.sv
// Command-driven Bresenham rasteriser issuing one port-B write per line point.
// DRAW_CLIP_EN: accept off-screen endpoints and skip the writes for off-screen points.
module line_draw_engine
    import gfx_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CX_W-1:0] x0,
    input  logic [CX_W-1:0] x1,
    input  logic [CY_W-1:0] y0,
    input  logic [CY_W-1:0] y1,
    input  logic            color,
    output logic [X_W-1:0]  x_b,
    output logic [Y_W-1:0]  y_b,
    output logic            in_b,
    output logic            write_b,
    input  logic            rdy_b,
    output logic            busy,
    output logic            done,
    output logic            err
);

    draw_state_t      state, state_n;
    pixel_xy_t        p0_r, p1_r, cur_r, nxt;
    logic             color_r;
    logic [ERR_W-1:0] dx_r, dy_r, acc_r, acc_next;
    logic             sx_neg_r, sy_neg_r;
    logic [ERR_W-1:0] diff_x, diff_y, dx_s, dy_s;
    logic             cmd_bad, visible, at_end;
    logic             accept, reject, finish;

`ifdef DRAW_CLIP_EN
    assign cmd_bad = 1'b0;
    assign visible = on_screen(cur_r);
`else
    assign cmd_bad = (x0 >= X_W'(SCREEN_W)) || (x1 >= X_W'(SCREEN_W)) ||
                     (y0 >= Y_W'(SCREEN_H)) || (y1 >= Y_W'(SCREEN_H));
    assign visible = 1'b1;
`endif

    assign at_end    = (cur_r == p1_r);
    assign busy      = (state != ST_IDLE);
    assign cmd_ready = !busy;
    assign write_b   = (state == ST_WRITE) && visible;
    assign x_b       = cur_r.x[X_W-1:0];
    assign y_b       = cur_r.y[Y_W-1:0];

    always_comb begin
        diff_x = p1_r.x - p0_r.x;
        diff_y = p1_r.y - p0_r.y;
        dx_s   = diff_x[ERR_W-1] ? -diff_x : diff_x;
        dy_s   = diff_y[ERR_W-1] ? diff_y : -diff_y;
    end

    bresenham_step u_step (
        .acc      (acc_r),
        .dx       (dx_r),
        .dy       (dy_r),
        .sx_neg   (sx_neg_r),
        .sy_neg   (sy_neg_r),
        .cur      (cur_r),
        .acc_next (acc_next),
        .nxt      (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reject  = 1'b0;
        finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = ST_SETUP;
                    end
                end
            end
            ST_SETUP: state_n = ST_WRITE;
            ST_WRITE: begin
                // An invisible point counts as acknowledged straight away.
                if (rdy_b || !visible) begin
                    if (at_end) begin
                        finish  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_STEP;
                    end
                end
            end
            ST_STEP:  state_n = ST_WRITE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_r     <= '0;
            p1_r     <= '0;
            cur_r    <= '0;
            color_r  <= 1'b0;
            dx_r     <= '0;
            dy_r     <= '0;
            acc_r    <= '0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
            in_b     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= finish;
            err  <= reject;
            if (accept) begin
                p0_r.x  <= ext_x(x0);
                p0_r.y  <= ext_y(y0);
                p1_r.x  <= ext_x(x1);
                p1_r.y  <= ext_y(y1);
                color_r <= color;
            end
            case (state)
                ST_SETUP: begin
                    dx_r     <= dx_s;
                    dy_r     <= dy_s;
                    acc_r    <= dx_s + dy_s;
                    sx_neg_r <= diff_x[ERR_W-1] || (diff_x == '0);
                    sy_neg_r <= diff_y[ERR_W-1] || (diff_y == '0);
                    cur_r    <= p0_r;
                    in_b     <= color_r;
                end
                ST_STEP: begin
                    acc_r <= acc_next;
                    cur_r <= nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: directed and random lines against a point-list model.
// Build with DRAW_CLIP_EN defined to exercise off-screen skipping instead of rejection.
module tb_line_draw_engine;
    import gfx_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CX_W-1:0] x0, x1;
    logic [CY_W-1:0] y0, y1;
    logic            color;
    logic [X_W-1:0]  x_b;
    logic [Y_W-1:0]  y_b;
    logic            in_b;
    logic            write_b;
    logic            rdy_b;
    logic            busy;
    logic            done;
    logic            err;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [17:0] exp_q[$];
    logic [17:0] cap_q[$];

    line_draw_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .color     (color),
        .x_b       (x_b),
        .y_b       (y_b),
        .in_b      (in_b),
        .write_b   (write_b),
        .rdy_b     (rdy_b),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [17:0] pk(input int x, input int y, input bit c);
        return {x[8:0], y[7:0], c};
    endfunction

    // Reference: walk the line with integer Bresenham and keep on-screen points.
    function automatic void model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                                       input bit col);
        int x, y, dx, dy, sx, sy, e, e2;
        exp_q.delete();
        dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx = (ax0 < ax1) ? 1 : -1;
        sy = (ay0 < ay1) ? 1 : -1;
        e  = dx + dy;
        x  = ax0;
        y  = ay0;
        for (int n = 0; n < 4000; n++) begin
            if (x >= 0 && x < SCREEN_W && y >= 0 && y < SCREEN_H) exp_q.push_back(pk(x, y, col));
            if (x == ax1 && y == ay1) break;
            e2 = 2 * e;
            if (e2 >= dy) begin e += dy; x += sx; end
            if (e2 <= dx) begin e += dx; y += sy; end
        end
    endfunction

    // mode 0: rdy_b tied high; mode 1: random rdy_b. stall_pix holds rdy_b low 7 cycles on that pixel.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1, input bit col,
                            input int mode, input int stall_pix, input string tag);
        int          cyc, first_w, pix, hold;
        bit          got_done, saw_err, pw, pr, after_hs;
        logic [17:0] prev;
        cap_q.delete();
        @(negedge clk);
        x0 = ax0[CX_W-1:0];
        y0 = ay0[CY_W-1:0];
        x1 = ax1[CX_W-1:0];
        y1 = ay1[CY_W-1:0];
        color = col;
        cmd_valid = 1'b1;
        check({tag, " ready"}, 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1; first_w = -1; pix = 0; hold = 0;
        got_done = 0; saw_err = 0; pw = 0; pr = 0; after_hs = 0; prev = '0;
        while (!got_done && cyc < 5000) begin
            if (err) saw_err = 1;
            if (done) begin
                got_done = 1;
            end else begin
                if (pw && !pr) check({tag, " hold"}, {write_b, x_b, y_b, in_b}, {1'b1, prev});
                if (after_hs) check({tag, " gap"}, 32'(write_b), 0);
                if (write_b && first_w < 0) first_w = cyc;
                rdy_b = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (write_b && pix == stall_pix && hold < 7) begin
                    rdy_b = 1'b0;
                    hold++;
                end
                after_hs = write_b && rdy_b;
                if (after_hs) begin
                    cap_q.push_back({x_b, y_b, in_b});
                    pix++;
                end
                pw = write_b; pr = rdy_b; prev = {x_b, y_b, in_b};
                @(negedge clk);
                cyc++;
            end
        end
        rdy_b = 1'b0;
        check({tag, " done"}, 32'(got_done), 1);
        check({tag, " no_err"}, 32'(saw_err), 0);
        check({tag, " first_w"}, first_w, (exp_q.size() > 0) ? 2 : -1);
        check({tag, " count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s pt%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        if (stall_pix >= 0) check({tag, " stall_len"}, hold, 7);
        @(negedge clk);
        check({tag, " done_once"}, {done, cmd_ready}, 2'b01);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0, ry0, rx1, ry1;
        rst_n = 1'b0; cmd_valid = 1'b0; rdy_b = 1'b0; color = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #12;
        check("reset ctl", {cmd_ready, write_b, busy, done, err}, 5'b10000);
        check("reset pos", {x_b, y_b, in_b}, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        exp_q.delete(); exp_q.push_back(pk(10, 20, 1));
        run_line(10, 20, 10, 20, 1, 0, -1, "degen");

        model_line(0, 199, 319, 199, 1);
        run_line(0, 199, 319, 199, 1, 0, -1, "horiz");

        exp_q.delete();
        exp_q.push_back(pk(5, 0, 1)); exp_q.push_back(pk(5, 1, 1)); exp_q.push_back(pk(6, 2, 1));
        exp_q.push_back(pk(6, 3, 1)); exp_q.push_back(pk(6, 4, 1));
        run_line(5, 0, 6, 4, 1, 0, -1, "steep");

        exp_q.delete();
        exp_q.push_back(pk(3, 3, 0)); exp_q.push_back(pk(2, 2, 0));
        exp_q.push_back(pk(1, 1, 0)); exp_q.push_back(pk(0, 0, 0));
        run_line(3, 3, 0, 0, 0, 0, -1, "revdiag");

        model_line(0, 0, 5, 3, 1);
        run_line(0, 0, 5, 3, 1, 0, 1, "stall");

        // Reset in the middle of a line.
        @(negedge clk);
        x0 = '0; y0 = '0; x1 = CX_W'(100); y1 = '0; color = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; rdy_b = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4 && !write_b; i++) @(negedge clk);
        check("rst pre_write", 32'(write_b), 1);
        #2 rst_n = 1'b0;
        #1 check("rst write_b", {write_b, busy}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1; rdy_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst after", {done, cmd_ready, write_b}, 3'b010);
        end

`ifdef DRAW_CLIP_EN
        exp_q.delete(); exp_q.push_back(pk(318, 0, 1)); exp_q.push_back(pk(319, 0, 1));
        run_line(318, 0, 321, 0, 1, 0, -1, "clip");
        model_line(-5, -3, 40, 210, 1);
        run_line(-5, -3, 40, 210, 1, 1, -1, "clip_rand");
`else
        @(negedge clk);
        x0 = '0; y0 = '0; x1 = 9'd320; y1 = '0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rej err", {err, cmd_ready, write_b, done}, 4'b1100);
        @(negedge clk);
        check("rej once", {err, busy, write_b}, 3'b000);
        x0 = 9'd7; y0 = 8'd200; x1 = 9'd7; y1 = 8'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rej y err", {err, cmd_ready, write_b}, 3'b110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rej idle", {err, busy, write_b, done}, 4'b0000);
        end
`endif

        for (int t = 0; t < 8; t++) begin
            rx0 = $urandom_range(0, SCREEN_W - 1);
            ry0 = $urandom_range(0, SCREEN_H - 1);
            rx1 = $urandom_range(0, SCREEN_W - 1);
            ry1 = $urandom_range(0, SCREEN_H - 1);
            if (t < 4) begin
                rx1 = (rx0 + 30 < SCREEN_W) ? rx0 + $urandom_range(0, 30) : rx0 - $urandom_range(0, 30);
                ry1 = (ry0 + 30 < SCREEN_H) ? ry0 + $urandom_range(0, 30) : ry0 - $urandom_range(0, 30);
            end
            model_line(rx0, ry0, rx1, ry1, t[0]);
            run_line(rx0, ry0, rx1, ry1, t[0], 1, -1, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
